// File: rtl/tahmin_kontrol.sv
// Game controller for the keypad-guess datapath: latches the secret, counts
// right/down presses, evaluates guesses and tracks attempts and win/lose status.
module tahmin_kontrol #(
  parameter int unsigned MAX_HAK = 3,
  parameter int unsigned HAK_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             basla,
  input  logic [3:0]       sayi_giris,
  input  logic             sag_btn,
  input  logic             asagi_btn,
  input  logic             onay,
  input  logic             tahmin_dogru,
  output logic [1:0]       sag_adim,
  output logic [1:0]       asagi_adim,
  output logic [3:0]       sayi,
  output logic [HAK_W-1:0] kalan_hak,
  output logic [HAK_W-1:0] deneme,
  output logic             oyun_aktif,
  output logic             kazandi,
  output logic             kaybetti
);

  localparam logic [HAK_W-1:0] MaxHak = HAK_W'(MAX_HAK);
  localparam logic [HAK_W-1:0] Bir    = HAK_W'(1);

  typedef enum logic [2:0] {
    StBosta,
    StGiris,
    StKontrol,
    StKazandi,
    StKaybetti
  } state_e;

  state_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBosta;
      sag_adim   <= 2'd0;
      asagi_adim <= 2'd0;
      sayi       <= 4'd0;
      kalan_hak  <= '0;
      deneme     <= '0;
    end else begin
      case (state_q)
        StBosta, StKazandi, StKaybetti: begin
          if (basla) begin
            sayi       <= sayi_giris;
            kalan_hak  <= MaxHak;
            deneme     <= '0;
            sag_adim   <= 2'd0;
            asagi_adim <= 2'd0;
            state_q    <= StGiris;
          end
        end
        StGiris: begin
          // Confirm wins over any step press in the same cycle.
          if (onay) begin
            state_q <= StKontrol;
          end else begin
            if (sag_btn && (sag_adim != 2'd3)) sag_adim <= sag_adim + 2'd1;
            if (asagi_btn && (asagi_adim != 2'd3)) asagi_adim <= asagi_adim + 2'd1;
          end
        end
        StKontrol: begin
          deneme <= deneme + Bir;
          if (tahmin_dogru) begin
            state_q <= StKazandi;
          end else begin
            kalan_hak <= kalan_hak - Bir;
            if (kalan_hak == Bir) begin
              state_q <= StKaybetti;
            end else begin
              sag_adim   <= 2'd0;
              asagi_adim <= 2'd0;
              state_q    <= StGiris;
            end
          end
        end
        default: state_q <= StBosta;
      endcase
    end
  end

  assign oyun_aktif = (state_q == StGiris) || (state_q == StKontrol);
  assign kazandi    = (state_q == StKazandi);
  assign kaybetti   = (state_q == StKaybetti);

endmodule
